keypad_scan_ctrl: RTL and testbench
===================================

Name: keypad_scan_ctrl

Overview:
- Parametrised keypad front end that replaces the fixed 2-bit scan counter and 4-bit keyboard encoder pair.
- Drives a ROWS x COLS matrix one row at a time and samples the columns.
- Debounces every key independently and queues press/release events in a small FIFO.
- The register bank consumes events through a valid/ready handshake.

Parameters:
- ROWS, 4, number of matrix rows driven (>=2).
- COLS, 4, number of matrix columns sensed (>=1).
- SCAN_DIV, 16, clock cycles each row stays driven; must be >= COLS+2.
- DEBOUNCE, 4, consecutive identical samples of a key needed to change its state (>=1).
- FIFO_DEPTH, 4, event queue entries; power of two, >=2.

Ports:
- clk, input, 1, system clock; all state on its rising edge.
- reset, input, 1, asynchronous active-high reset.
- col_in, input, COLS, column sense lines; 1 = key closed on the driven row.
- row_out, output, ROWS, one-hot row drive.
- evt_valid, output, 1, FIFO non-empty.
- evt_data, output, CODE_W+1, head entry: MSB = press(1)/release(0), low CODE_W bits = key code. CODE_W = max(1, $clog2(ROWS*COLS)).
- evt_ready, input, 1, consumer accepts the head entry.
- fifo_count, output, $clog2(FIFO_DEPTH+1), entries currently queued.
- overflow, output, 1, sticky flag: an event was dropped.

Behaviour:
- Reset (async, immediate) values:
  - row index = 0, row_out = 1 (row 0 driven), divider = 0.
  - All keys released, all debounce counters = 0.
  - FIFO empty: evt_valid = 0, fifo_count = 0, evt_data = 0.
  - overflow = 0.
- Scanning:
  - The divider counts 0..SCAN_DIV-1. At SCAN_DIV-1 the row index advances, wrapping from ROWS-1 to 0.
  - row_out = one-hot(row index).
  - One frame = ROWS*SCAN_DIV cycles.
- Sampling:
  - col_in is registered, together with the current row index, on divider = SCAN_DIV-1 (the last cycle of the row period, which allows settling).
- Evaluation:
  - During divider cycles 0..COLS-1 of the following row period, column c = divider of the sampled row is evaluated, one key per cycle.
  - key code = row*COLS + c.
- Per-key debounce:
  - Each key holds a stable bit and a counter of width $clog2(DEBOUNCE+1).
  - Sample == stable: counter clears to 0.
  - Sample != stable: counter increments.
  - When the counter reaches DEBOUNCE: stable toggles, counter clears, and one event {new stable, code} is pushed.
  - A pulse shorter than DEBOUNCE consecutive samples produces no event.
- Latency:
  - An event is visible at the FIFO head (if the FIFO was empty) the cycle after its evaluation cycle.
  - Press detection takes DEBOUNCE frames of continuous closure.
- FIFO:
  - Push order = evaluation order, so within a row the lower column comes first.
  - Pop occurs when evt_valid && evt_ready. evt_data holds stable while evt_valid && !evt_ready.
  - Push while full without a simultaneous pop: the event is dropped, overflow is set, and the key's stable state still updates.
  - Push and pop in the same cycle while full: both succeed, no overflow, count unchanged.
  - Push and pop while empty: not possible, since evt_valid = 0.
- overflow clears only on reset.
- Reset mid-operation: all in-flight debounce progress and queued events are discarded. A key held across reset is re-reported as a press after DEBOUNCE frames.
- fifo_count never exceeds FIFO_DEPTH. Pointers wrap modulo FIFO_DEPTH.

Test Plan:
All scenarios use defaults (ROWS=COLS=4, SCAN_DIV=16, DEBOUNCE=4, FIFO_DEPTH=4; frame = 64 cycles).
1. Release reset, col_in=0 -> row_out=0001 at cycle 0, 0010 at cycle 16, 1000 at cycle 48, 0001 at cycle 64; evt_valid=0 and overflow=0 throughout.
2. Model key row2/col1 closed continuously, evt_ready=1 -> exactly one event evt_data=1_1001 (press, code 9) after the 4th row-2 sample. Open the key -> one event 0_1001 after 4 further frames.
3. Bounce on key 0: closed 3 frames, open 1 frame, closed 4 frames -> exactly one press event (code 0), at the end of the 4-frame run; no release event.
4. Keys row1/col0 and row1/col3 closed together, evt_ready=1 -> press code 4 then press code 7, pushed on divider cycles 0 and 3 of the same row period.
5. evt_ready=0; press then release keys 0, 5, 10 (6 events) -> fifo_count=4, overflow=1. Drain with evt_ready=1 -> 1_0000, 0_0000, 1_0101, 0_0101 in order. overflow stays 1 until reset.
6. Key 0 held 2 frames, then reset pulsed for 3 cycles while the key stays held -> all outputs at reset values. The press event for code 0 appears only after 4 full frames following reset release.

Source files
------------

// File: rtl/keypad_scan_ctrl.sv
// Keypad matrix front end: row scanning, per-key debounce and a small
// press/release event FIFO drained through a valid/ready handshake.
module keypad_scan_ctrl #(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int SCAN_DIV   = 16,
  parameter int DEBOUNCE   = 4,
  parameter int FIFO_DEPTH = 4,
  localparam int KEYS      = ROWS * COLS,
  localparam int CODE_W    = (KEYS > 1) ? $clog2(KEYS) : 1,
  localparam int FCNT_W    = $clog2(FIFO_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [COLS-1:0]   col_in,
  output logic [ROWS-1:0]   row_out,
  output logic              evt_valid,
  output logic [CODE_W:0]   evt_data,
  input  logic              evt_ready,
  output logic [FCNT_W-1:0] fifo_count,
  output logic              overflow
);

  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  // Scan state
  logic [DIV_W-1:0] div_q, div_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [ROWS-1:0]  row_out_q, row_out_d;
  logic [COLS-1:0]  samp_q, samp_d;
  logic [ROW_W-1:0] samp_row_q, samp_row_d;

  // Debounce state
  logic [KEYS-1:0]             stable_q, stable_d;
  logic [KEYS-1:0][CNT_W-1:0]  cnt_q, cnt_d;

  // FIFO state
  logic [FIFO_DEPTH-1:0][CODE_W:0] mem_q, mem_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [FCNT_W-1:0] count_q, count_d;
  logic              ovf_q, ovf_d;

  logic              eval_en_s;
  logic [COL_W-1:0]  eval_col_s;
  logic [CODE_W-1:0] eval_code_s;
  logic              push_s;
  logic [CODE_W:0]   push_data_s;
  logic              pop_s;
  logic              full_s;
  logic              push_ok_s;

  // Row divider, row advance and end-of-period column capture
  always_comb begin
    div_d      = div_q;
    row_d      = row_q;
    row_out_d  = row_out_q;
    samp_d     = samp_q;
    samp_row_d = samp_row_q;
    if (div_q == DIV_W'(SCAN_DIV - 1)) begin
      div_d      = '0;
      samp_d     = col_in;
      samp_row_d = row_q;
      if (row_q == ROW_W'(ROWS - 1)) begin
        row_d = '0;
      end else begin
        row_d = row_q + ROW_W'(1);
      end
      row_out_d        = '0;
      row_out_d[row_d] = 1'b1;
    end else begin
      div_d = div_q + DIV_W'(1);
    end
  end

  assign eval_en_s   = (div_q < DIV_W'(COLS));
  assign eval_col_s  = div_q[COL_W-1:0];
  assign eval_code_s = CODE_W'((int'(samp_row_q) * COLS) + int'(eval_col_s));

  // One key of the previously sampled row is debounced per cycle
  always_comb begin
    stable_d    = stable_q;
    cnt_d       = cnt_q;
    push_s      = 1'b0;
    push_data_s = '0;
    if (eval_en_s) begin
      if (samp_q[eval_col_s] == stable_q[eval_code_s]) begin
        cnt_d[eval_code_s] = '0;
      end else if (cnt_q[eval_code_s] == CNT_W'(DEBOUNCE - 1)) begin
        stable_d[eval_code_s] = samp_q[eval_col_s];
        cnt_d[eval_code_s]    = '0;
        push_s                = 1'b1;
        push_data_s           = {samp_q[eval_col_s], eval_code_s};
      end else begin
        cnt_d[eval_code_s] = cnt_q[eval_code_s] + CNT_W'(1);
      end
    end else begin
      push_s = 1'b0;
    end
  end

  assign pop_s     = (count_q != '0) && evt_ready;
  assign full_s    = (count_q == FCNT_W'(FIFO_DEPTH));
  // A pop in the same cycle frees the slot a full FIFO would otherwise deny
  assign push_ok_s = push_s && (!full_s || pop_s);

  // Event FIFO pointers, occupancy and sticky drop flag
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (push_ok_s) begin
      mem_d[wr_ptr_q] = push_data_s;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end else begin
      ovf_d = ovf_q | push_s;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_s})
      2'b10:   count_d = count_q + FCNT_W'(1);
      2'b01:   count_d = count_q - FCNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q      <= '0;
      row_q      <= '0;
      row_out_q  <= ROWS'(1);
      samp_q     <= '0;
      samp_row_q <= '0;
      stable_q   <= '0;
      cnt_q      <= '0;
      mem_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
    end else begin
      div_q      <= div_d;
      row_q      <= row_d;
      row_out_q  <= row_out_d;
      samp_q     <= samp_d;
      samp_row_q <= samp_row_d;
      stable_q   <= stable_d;
      cnt_q      <= cnt_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
    end
  end

  assign row_out    = row_out_q;
  assign evt_valid  = (count_q != '0);
  assign evt_data   = mem_q[rd_ptr_q];
  assign fifo_count = count_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Scoreboard bench for keypad_scan_ctrl: a key-matrix model drives col_in,
// expected events are queued with their arrival cycle and checked by a monitor.
module tb_keypad_scan_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] col_in;
  logic [3:0] row_out;
  logic       evt_valid;
  logic [4:0] evt_data;
  logic       evt_ready = 1'b1;
  logic [2:0] fifo_count;
  logic       overflow;

  logic [15:0] keys = 16'h0000;
  int cyc;
  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [4:0] data;
    int         at;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  keypad_scan_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .col_in     (col_in),
    .row_out    (row_out),
    .evt_valid  (evt_valid),
    .evt_data   (evt_data),
    .evt_ready  (evt_ready),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  // Key matrix: a closed key shorts its row drive onto its column
  always_comb begin
    col_in = 4'b0000;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (row_out[r] && keys[r*4+c]) col_in[c] = 1'b1;
      end
    end
  end

  // Cycle n = the cycle whose clock count since reset release is n
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every accepted event is matched against the scoreboard
  always @(negedge clk) begin
    if (!reset && evt_valid && evt_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_event: got %b at cycle %0d, expected none", evt_data, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("evt_data", 32'(evt_data), 32'(mon_e.data));
        if (mon_e.at >= 0) check("evt_cycle", 32'(cyc), 32'(mon_e.at));
      end
    end
  end

  task automatic chk_reset_vals(input string tag);
    check({tag, "_rst_row_out"},    32'(row_out),    32'h1);
    check({tag, "_rst_evt_valid"},  32'(evt_valid),  32'h0);
    check({tag, "_rst_fifo_count"}, 32'(fifo_count), 32'h0);
    check({tag, "_rst_evt_data"},   32'(evt_data),   32'h0);
    check({tag, "_rst_overflow"},   32'(overflow),   32'h0);
  endtask

  task automatic reset_pulse(input string tag);
    reset = 1'b1;
    #1;
    chk_reset_vals(tag);
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic start(input string tag, input logic [15:0] k, input logic rdy);
    @(negedge clk);
    keys      = k;
    evt_ready = rdy;
    reset_pulse(tag);
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic expect_evt(input logic [4:0] d, input int at);
    exp_t e;
    e.data = d;
    e.at   = at;
    exp_q.push_back(e);
  endtask

  initial begin
    // 1: idle scan sequence
    start("s1", 16'h0000, 1'b1);
    check("s1_row_c0", 32'(row_out), 32'h1);
    wait_cyc(15); check("s1_row_c15", 32'(row_out), 32'h1);
    wait_cyc(16); check("s1_row_c16", 32'(row_out), 32'h2);
    wait_cyc(32); check("s1_row_c32", 32'(row_out), 32'h4);
    wait_cyc(48); check("s1_row_c48", 32'(row_out), 32'h8);
    wait_cyc(64); check("s1_row_c64", 32'(row_out), 32'h1);
    check("s1_valid", 32'(evt_valid), 32'h0);
    check("s1_ovf",   32'(overflow),  32'h0);

    // 2: key 9 press then release
    start("s2", 16'h0200, 1'b1);
    expect_evt(5'b1_1001, 242);
    wait_cyc(256);
    keys = 16'h0000;
    expect_evt(5'b0_1001, 498);
    wait_cyc(600);
    check("s2_drained", 32'(exp_q.size()), 32'h0);

    // 3: bounce on key 0 (3 closed, 1 open, then held)
    start("s3", 16'h0001, 1'b1);
    expect_evt(5'b1_0000, 465);
    wait_cyc(192); keys = 16'h0000;
    wait_cyc(256); keys = 16'h0001;
    wait_cyc(700);
    check("s3_drained", 32'(exp_q.size()), 32'h0);

    // 4: keys 4 and 7 in the same row
    start("s4", 16'h0090, 1'b1);
    expect_evt(5'b1_0100, 225);
    expect_evt(5'b1_0111, 228);
    wait_cyc(300);
    check("s4_drained", 32'(exp_q.size()), 32'h0);

    // 5: FIFO fills with no consumer, then overflow, then drain
    start("s5", 16'h0001, 1'b0);
    wait_cyc(256);  keys = 16'h0000;
    wait_cyc(512);  keys = 16'h0020;
    wait_cyc(768);  keys = 16'h0000;
    wait_cyc(1024); keys = 16'h0400;
    wait_cyc(1200);
    check("s5_full_count", 32'(fifo_count), 32'h4);
    check("s5_full_ovf",   32'(overflow),   32'h0);
    check("s5_full_valid", 32'(evt_valid),  32'h1);
    check("s5_head_hold",  32'(evt_data),   32'h10);
    wait_cyc(1280); keys = 16'h0000;
    wait_cyc(1600);
    check("s5_ovf_count", 32'(fifo_count), 32'h4);
    check("s5_ovf_set",   32'(overflow),   32'h1);
    check("s5_ovf_head",  32'(evt_data),   32'h10);
    expect_evt(5'b1_0000, -1);
    expect_evt(5'b0_0000, -1);
    expect_evt(5'b1_0101, -1);
    expect_evt(5'b0_0101, -1);
    @(posedge clk);
    #1 evt_ready = 1'b1;
    wait_cyc(1620);
    check("s5_drain_count", 32'(fifo_count), 32'h0);
    check("s5_drain_valid", 32'(evt_valid),  32'h0);
    check("s5_ovf_sticky",  32'(overflow),   32'h1);
    check("s5_drained",     32'(exp_q.size()), 32'h0);

    // 6: reset while key 0 is held discards debounce progress
    start("s6a", 16'h0001, 1'b1);
    wait_cyc(128);
    reset_pulse("s6b");
    expect_evt(5'b1_0000, 209);
    wait_cyc(300);
    check("s6_drained", 32'(exp_q.size()), 32'h0);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
